// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes results at start and
// commits them after a fixed busy window so the pipeline sees multi-cycle latency.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic [3:0]  E_MDUop,
    output logic [31:0] E_MUresult,
    output logic        E_start,
    output logic        E_busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Sign-magnitude division: quotient truncates toward zero, remainder takes the
    // dividend's sign; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic [31:0] ua, ub, uq, ur, q, r;
        ua = (a < 0) ? 32'(-a) : 32'(a);
        ub = (b < 0) ? 32'(-b) : 32'(b);
        uq = (ub == 32'd0) ? 32'd0 : ua / ub;
        ur = (ub == 32'd0) ? 32'd0 : ua % ub;
        q  = ((a < 0) != (b < 0)) ? (~uq + 32'd1) : uq;
        r  = (a < 0) ? (~ur + 32'd1) : ur;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        q = (b == 32'd0) ? 32'd0 : a / b;
        r = (b == 32'd0) ? 32'd0 : a % b;
        return {r, q};
    endfunction

    logic [31:0]        hi, lo, phi, plo;
    logic [CNT_W-1:0]   cnt;
    logic               pwr;
    logic               busy;
    logic signed [31:0] a_s, b_s;
    logic signed [63:0] mul_s;
    logic [63:0]        mul_u;
    logic [63:0]        res_p0;
    logic               is_div_p0;

    assign a_s = $signed(E_A);
    assign b_s = $signed(E_B);

    always_comb begin
        mul_s     = $signed({{32{a_s[31]}}, a_s}) * $signed({{32{b_s[31]}}, b_s});
        mul_u     = {32'd0, E_A} * {32'd0, E_B};
        is_div_p0 = (E_MDUop == OP_DIV) || (E_MDUop == OP_DIVU);
        case (E_MDUop)
            OP_MULT:  res_p0 = mul_s;
            OP_MULTU: res_p0 = mul_u;
            OP_DIV:   res_p0 = div_signed(a_s, b_s);
            OP_DIVU:  res_p0 = div_unsigned(E_A, E_B);
            default:  res_p0 = 64'd0;
        endcase
    end

    assign E_start = (E_MDUop >= OP_MULT) && (E_MDUop <= OP_DIVU) && !busy;
    assign E_busy  = busy;

    always_comb begin
        case (E_MDUop)
            OP_MFHI: E_MUresult = hi;
            OP_MFLO: E_MUresult = lo;
            default: E_MUresult = 32'd0;
        endcase
    end

    // Start captures the result into the pending pair; commit happens on the last busy edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            phi  <= 32'd0;
            plo  <= 32'd0;
            cnt  <= '0;
            pwr  <= 1'b0;
            busy <= 1'b0;
        end else if (E_start) begin
            phi  <= res_p0[63:32];
            plo  <= res_p0[31:0];
            pwr  <= !(is_div_p0 && (E_B == 32'd0));
            cnt  <= is_div_p0 ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy <= 1'b1;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                if (pwr) begin
                    hi <= phi;
                    lo <= plo;
                end
            end
        end else if (E_MDUop == OP_MTHI) begin
            hi <= E_A;
        end else if (E_MDUop == OP_MTLO) begin
            lo <= E_A;
        end
    end

endmodule
